fp_div_seq: RTL

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_div_seq_pkg.sv | 31 +++
 rtl/fp_mant_div_iter.sv | 60 ++++++
 rtl/fp_div_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fp_div_seq_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fp_div_seq_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = 24;
    localparam int unsigned QUOT_W = 26;
    localparam int unsigned REM_W  = 26;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned EXPC_W = 10;

    localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;
    localparam int unsigned       BIAS = 127;
    localparam int unsigned       ITER = 26;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UNPACK   = 3'd1,
        S_DIVIDE   = 3'd2,
        S_NORM_RND = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_mant_div_iter.sv
// Restoring radix-2 mantissa divider: one quotient bit per step, MSB weight 2^0.
module fp_mant_div_iter
    import fp_div_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic [QUOT_W-1:0] quot,
    output logic              sticky
);

    logic [REM_W-1:0]  rem_q, rem_d;
    logic [MANT_W-1:0] dvs_q, dvs_d;
    logic [QUOT_W-1:0] quot_q, quot_d;
    logic              sticky_q, sticky_d;
    logic [REM_W-1:0]  diff_c;
    logic              ge_c;

    // Compare/subtract, then shift the partial remainder for the next bit
    always_comb begin
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quot_d   = quot_q;
        sticky_d = sticky_q;
        diff_c   = rem_q - REM_W'(dvs_q);
        ge_c     = (rem_q >= REM_W'(dvs_q));
        if (load) begin
            rem_d    = REM_W'(dividend);
            dvs_d    = divisor;
            quot_d   = '0;
            sticky_d = 1'b0;
        end else if (step) begin
            rem_d    = (ge_c ? diff_c : rem_q) << 1;
            quot_d   = {quot_q[QUOT_W-2:0], ge_c};
            sticky_d = (rem_d != '0);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            quot_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quot_q   <= quot_d;
            sticky_q <= sticky_d;
        end
    end

    assign quot   = quot_q;
    assign sticky = sticky_q;

endmodule

// File: rtl/fp_div_seq.sv
// Fixed-latency sequential IEEE-754 single-precision divider (RNE, flush-to-zero).
module fp_div_seq
    import fp_div_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] q
);

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d, done_q, done_d;
    logic [WORD_W-1:0]        q_q, q_d;
    fp32_t                    a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     sign_q, sign_d;
    logic signed [EXPC_W-1:0] exp_q, exp_d;
    logic                     spec_q, spec_d;
    logic [WORD_W-1:0]        spec_val_q, spec_val_d;

    logic a_zero_c, a_inf_c, a_nan_c, b_zero_c, b_inf_c, b_nan_c, sign_c, spec_c;
    logic [WORD_W-1:0]        spec_val_c, rnd_res_c;
    logic [QUOT_W-1:0]        quot_c;
    logic                     sticky_c, load_c, step_c;
    logic [MANT_W-1:0]        mant_c;
    logic                     guard_c, rbit_c, rnd_up_c;
    logic [MANT_W:0]          mant_rnd_c;
    logic [FRAC_W-1:0]        frac_c;
    logic signed [EXPC_W-1:0] exp_norm_c, exp_fin_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_UNPACK;
            S_UNPACK:   state_d = S_DIVIDE;
            S_DIVIDE:   if (cnt_q == CNT_W'(ITER - 1)) state_d = S_NORM_RND;
            S_NORM_RND: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Handshake outputs, registered alongside the state they describe
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Operand classification and special-case result; denormals count as zero
    always_comb begin
        a_zero_c   = (a_q.exp == '0);
        a_inf_c    = (a_q.exp == '1) && (a_q.frac == '0);
        a_nan_c    = (a_q.exp == '1) && (a_q.frac != '0);
        b_zero_c   = (b_q.exp == '0);
        b_inf_c    = (b_q.exp == '1) && (b_q.frac == '0);
        b_nan_c    = (b_q.exp == '1) && (b_q.frac != '0);
        sign_c     = a_q.sign ^ b_q.sign;
        spec_c     = 1'b0;
        spec_val_c = '0;
        if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c)) begin
            spec_c     = 1'b1;
            spec_val_c = QNAN;
        end else if (a_inf_c || b_zero_c) begin
            spec_c     = 1'b1;
            spec_val_c = {sign_c, 8'hFF, 23'd0};
        end else if (a_zero_c || b_inf_c) begin
            spec_c     = 1'b1;
            spec_val_c = {sign_c, 31'd0};
        end
    end

    // Normalize the raw quotient, round to nearest even, then range-check
    always_comb begin
        mant_c     = quot_c[QUOT_W-1:2];
        guard_c    = quot_c[1];
        rbit_c     = quot_c[0];
        exp_norm_c = exp_q;
        if (!quot_c[QUOT_W-1]) begin
            mant_c     = quot_c[QUOT_W-2:1];
            guard_c    = quot_c[0];
            rbit_c     = 1'b0;
            exp_norm_c = exp_q - 10'sd1;
        end
        rnd_up_c   = guard_c & (rbit_c | sticky_c | mant_c[0]);
        mant_rnd_c = {1'b0, mant_c} + (MANT_W + 1)'(rnd_up_c);
        frac_c     = mant_rnd_c[FRAC_W-1:0];
        exp_fin_c  = exp_norm_c;
        if (mant_rnd_c[MANT_W]) begin
            frac_c    = mant_rnd_c[FRAC_W:1];
            exp_fin_c = exp_norm_c + 10'sd1;
        end
        if (exp_fin_c >= 10'sd255)    rnd_res_c = {sign_q, 8'hFF, 23'd0};
        else if (exp_fin_c <= 10'sd0) rnd_res_c = {sign_q, 31'd0};
        else                          rnd_res_c = {sign_q, exp_fin_c[EXP_W-1:0], frac_c};
    end

    // Per-state datapath updates
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        q_d        = q_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d = fp32_t'(a);
                    b_d = fp32_t'(b);
                end
            end
            S_UNPACK: begin
                cnt_d      = '0;
                sign_d     = sign_c;
                exp_d      = $signed({2'b00, a_q.exp}) - $signed({2'b00, b_q.exp})
                           + $signed(EXPC_W'(BIAS));
                spec_d     = spec_c;
                spec_val_d = spec_val_c;
            end
            S_DIVIDE:   cnt_d = cnt_q + CNT_W'(1);
            S_NORM_RND: q_d = spec_q ? spec_val_q : rnd_res_c;
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            q_q        <= q_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
        end
    end

    assign load_c = (state_q == S_UNPACK);
    assign step_c = (state_q == S_DIVIDE);

    fp_mant_div_iter u_mant_div (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .step     (step_c),
        .dividend ({1'b1, a_q.frac}),
        .divisor  ({1'b1, b_q.frac}),
        .quot     (quot_c),
        .sticky   (sticky_c)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;

endmodule
